vend_order_issuer: RTL
======================

// Module: vend_order_issuer
// PURPOSE
//   Customer-side driver for the autoseller vending interface: buffers drink
//   orders from a host, issues each one to the seller when it signals ready,
//   waits for the seller's change/drink reply and hands the result back to the
//   host. Sits between host/control logic and the autoseller as its initiator.
// PARAMETERS
//   DEPTH    4   order FIFO entries (power of 2, >=2)
//   TIMEOUT  64  max cycles waited for a seller reply after issue (>=2)
//   CNT_W    8   width of completed-order counter
// PORTS
//   clk            in   1      rising-edge clock
//   reset_n        in   1      asynchronous reset, active low
//   ord_valid_i    in   1      host order valid
//   ord_ready_o    out  1      FIFO can accept order (= !full)
//   ord_money_i    in   6      inserted money for order
//   ord_type_i     in   2      drink type for order
//   res_valid_o    out  1      result valid, held until accepted
//   res_ready_i    in   1      host accepts result
//   res_change_o   out  6      change returned by seller
//   res_drink_o    out  2      drink returned by seller
//   res_timeout_o  out  1      result produced by timeout, not by seller
//   sell_ready_i   in   1      seller ready_o
//   sell_enable_o  out  1      to seller enable_i: 1-cycle order strobe
//   sell_money_o   out  6      to seller money_i
//   sell_type_o    out  2      to seller drinktype_i
//   sell_enable_i  in   1      seller enable_o: reply strobe
//   sell_change_i  in   6      seller change_o
//   sell_drink_i   in   2      seller drink_o
//   busy_o         out  1      state != IDLE or FIFO not empty
//   stray_o        out  1      sticky: seller reply seen outside WAIT
//   done_cnt_o     out  CNT_W  results accepted by host, wraps mod 2^CNT_W
// BEHAVIOUR
//   Reset: all outputs 0 except ord_ready_o=1; FIFO emptied, state IDLE,
//     timer 0. Reset mid-transaction discards queued and in-flight orders.
//   FIFO: push on ord_valid_i & ord_ready_o; ord_ready_o = !full, no bypass
//     (a pop while full does not raise ready in the same cycle).
//   FSM IDLE -> ISSUE when FIFO !empty & sell_ready_i (sampled at clk edge).
//   ISSUE (1 cycle): sell_enable_o=1, sell_money_o/sell_type_o = FIFO head;
//     head popped; timer cleared; -> WAIT. Outside ISSUE sell_enable_o,
//     sell_money_o, sell_type_o are all 0. All seller outputs are registered.
//   WAIT: timer +1 per cycle. On sell_enable_i: capture sell_change_i and
//     sell_drink_i into res_*, res_timeout_o=0, -> RESP. Else if timer ==
//     TIMEOUT-1: res_change_o=0, res_drink_o=0, res_timeout_o=1, -> RESP.
//     Reply and timeout in same cycle: reply wins, res_timeout_o=0.
//   RESP: res_valid_o=1, res_* stable until res_ready_i=1 that cycle;
//     then res_valid_o=0, done_cnt_o+1, -> IDLE. Next issue earliest
//     the cycle after returning to IDLE (one order in flight max).
//   Min latency order push -> sell_enable_o: 2 cycles (push, IDLE->ISSUE).
//   sell_enable_i in IDLE/ISSUE/RESP: ignored for data, sets stray_o (cleared
//     only by reset).
//   Host pushes continue in every state; FIFO order strictly preserved.
// TESTING
//   1 order money=0x32 type=2'b10, seller ready, reply 3 cycles after strobe
//     change=0x0A drink=2'b10 -> one sell_enable_o pulse with 0x32/10;
//     res_valid_o with 0x0A/10, timeout=0; done_cnt_o=1 after accept.
//   Push 5 orders with DEPTH=4, no seller ready -> ord_ready_o=0 after 4th,
//     5th held; release ready -> all 5 issued in push order.
//   Seller never replies, TIMEOUT=64 -> res_valid_o exactly 64 cycles after
//     strobe, res_timeout_o=1, change=0, drink=0.
//   Reply on cycle timer==63 -> res_timeout_o=0, reply data captured.
//   res_ready_i held 0 for 10 cycles in RESP -> res_* stable, no new
//     sell_enable_o; stray reply during RESP sets stray_o=1, data unchanged.
//   reset_n low while WAIT with 2 queued -> all outputs reset immediately,
//     FIFO empty, no strobe after release until new push.

Source files
------------

// File: rtl/vend_order_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_order_issuer_if
// Brief    : Host order/result handshakes and seller-side strobe/reply bus
//            for the vending order issuer.
// Revision : 1.0 - initial release
// ============================================================================
interface vend_order_issuer_if;
  // host order side
  logic       ord_valid_i;
  logic       ord_ready_o;
  logic [5:0] ord_money_i;
  logic [1:0] ord_type_i;
  // host result side
  logic       res_valid_o;
  logic       res_ready_i;
  logic [5:0] res_change_o;
  logic [1:0] res_drink_o;
  logic       res_timeout_o;
  // seller side
  logic       sell_ready_i;
  logic       sell_enable_o;
  logic [5:0] sell_money_o;
  logic [1:0] sell_type_o;
  logic       sell_enable_i;
  logic [5:0] sell_change_i;
  logic [1:0] sell_drink_i;

  // issuer view
  modport master (
    input  ord_valid_i, ord_money_i, ord_type_i, res_ready_i,
           sell_ready_i, sell_enable_i, sell_change_i, sell_drink_i,
    output ord_ready_o, res_valid_o, res_change_o, res_drink_o, res_timeout_o,
           sell_enable_o, sell_money_o, sell_type_o
  );

  // host / seller environment view
  modport slave (
    output ord_valid_i, ord_money_i, ord_type_i, res_ready_i,
           sell_ready_i, sell_enable_i, sell_change_i, sell_drink_i,
    input  ord_ready_o, res_valid_o, res_change_o, res_drink_o, res_timeout_o,
           sell_enable_o, sell_money_o, sell_type_o
  );
endinterface
`default_nettype wire

// File: rtl/vend_order_issuer.sv
`default_nettype none
// ============================================================================
// Module   : vend_order_issuer
// Brief    : Buffers host drink orders in a FIFO, strobes them one at a time
//            into the autoseller, waits (bounded) for its reply and returns
//            the change/drink result to the host.
// Revision : 1.0 - initial release
// ============================================================================
module vend_order_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  vend_order_issuer_if.master   bus,
  output logic                  busy_o,
  output logic                  stray_o,
  output logic [CNT_W-1:0]      done_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];
  logic [TW-1:0]    timer_q, timer_d;
  logic             sell_en_q, sell_en_d;
  logic [5:0]       sell_money_q, sell_money_d;
  logic [1:0]       sell_type_q, sell_type_d;
  logic [5:0]       res_change_q, res_change_d;
  logic [1:0]       res_drink_q, res_drink_d;
  logic             res_timeout_q, res_timeout_d;
  logic             stray_q, stray_d;
  logic [CNT_W-1:0] done_q, done_d;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // FIFO flags come only from registered pointers, so a pop never raises ready in the same cycle
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.ord_valid_i & ~full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage: entry packs {money, type}
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.ord_money_i, bus.ord_type_i};
  end

  // Next-state, FIFO pointer, timer and output-register computation
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    sell_en_d     = 1'b0;
    sell_money_d  = 6'd0;
    sell_type_d   = 2'd0;
    res_change_d  = res_change_q;
    res_drink_d   = res_drink_q;
    res_timeout_d = res_timeout_q;
    done_d        = done_q;
    pop           = 1'b0;
    // a seller reply anywhere but WAIT is unexpected and latched for debug
    stray_d       = stray_q | (bus.sell_enable_i & (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (!empty && bus.sell_ready_i) begin
          // register the head now so the strobe and its data appear together in ISSUE
          state_d      = S_ISSUE;
          pop          = 1'b1;
          sell_en_d    = 1'b1;
          sell_money_d = head[7:2];
          sell_type_d  = head[1:0];
          timer_d      = '0;
        end
      end
      S_ISSUE: begin
        // timer counts from the strobe, so WAIT cycle n sees timer == n
        state_d = S_WAIT;
        timer_d = timer_q + TW'(1);
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (bus.sell_enable_i) begin
          // a reply on the last allowed cycle still beats the timeout
          state_d       = S_RESP;
          res_change_d  = bus.sell_change_i;
          res_drink_d   = bus.sell_drink_i;
          res_timeout_d = 1'b0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d       = S_RESP;
          res_change_d  = 6'd0;
          res_drink_d   = 2'd0;
          res_timeout_d = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.res_ready_i) begin
          state_d = S_IDLE;
          done_d  = done_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // State and output registers; reset discards queued and in-flight orders
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      timer_q       <= '0;
      sell_en_q     <= 1'b0;
      sell_money_q  <= 6'd0;
      sell_type_q   <= 2'd0;
      res_change_q  <= 6'd0;
      res_drink_q   <= 2'd0;
      res_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
      done_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      timer_q       <= timer_d;
      sell_en_q     <= sell_en_d;
      sell_money_q  <= sell_money_d;
      sell_type_q   <= sell_type_d;
      res_change_q  <= res_change_d;
      res_drink_q   <= res_drink_d;
      res_timeout_q <= res_timeout_d;
      stray_q       <= stray_d;
      done_q        <= done_d;
    end
  end

  assign bus.ord_ready_o   = ~full;
  assign bus.res_valid_o   = (state_q == S_RESP);
  assign bus.res_change_o  = res_change_q;
  assign bus.res_drink_o   = res_drink_q;
  assign bus.res_timeout_o = res_timeout_q;
  assign bus.sell_enable_o = sell_en_q;
  assign bus.sell_money_o  = sell_money_q;
  assign bus.sell_type_o   = sell_type_q;
  assign busy_o            = (state_q != S_IDLE) || !empty;
  assign stray_o           = stray_q;
  assign done_cnt_o        = done_q;

endmodule
`default_nettype wire
